// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential instruction fetch with a slot-reserving response FIFO and redirect flush.
// Define FETCH_STATS_EN to add saturating fetched/flushed/stall counters.
module inst_fetch_queue #(
    parameter int                ADDR_W   = 8,
    parameter int                INST_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] inst_pc_plus1,
`ifdef FETCH_STATS_EN
    output logic [15:0]       stat_fetched,
    output logic [15:0]       stat_flushed,
    output logic [15:0]       stat_stall,
`endif
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = 8;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [CW-1:0]     r_count, r_out;
    logic [DW-1:0]     r_drop;
    logic [PW-1:0]     r_rd, r_wr, r_aq_rd, r_aq_wr;
    logic [INST_W-1:0] r_data [DEPTH];
    logic [ADDR_W-1:0] r_pc   [DEPTH];
    logic [ADDR_W-1:0] r_aq   [DEPTH];
    logic [CW:0]       w_used;
    logic              w_flush, w_issue, w_keep, w_push, w_pop;

    // Each outstanding request owns a FIFO slot, so count + outstanding bounds issue.
    assign w_flush        = rst || redirect_valid;
    assign w_used         = {1'b0, r_count} + {1'b0, r_out};
    assign imem_req_valid = !w_flush && (w_used < (CW+1)'(DEPTH));
    assign imem_addr      = r_fetch_pc;
    assign w_issue        = imem_req_valid && imem_req_ready;
    assign w_keep         = imem_rsp_valid && (r_drop == '0);
    assign w_push         = w_keep && !w_flush;
    assign inst_valid     = r_count != '0;
    assign w_pop          = inst_valid && inst_ready && !w_flush;
    assign inst_data      = inst_valid ? r_data[r_rd] : '0;
    assign inst_pc        = inst_valid ? r_pc[r_rd] : '0;
    assign inst_pc_plus1  = inst_pc + 1'b1;

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_fetch_pc <= rst ? RESET_PC : redirect_pc;
            r_count    <= '0;
            r_out      <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_aq_rd    <= '0;
            r_aq_wr    <= '0;
            // Requests still in memory come back later and must be discarded.
            r_drop     <= rst ? DW'(r_out) - DW'(w_keep) : r_drop + DW'(r_out) - DW'(imem_rsp_valid);
        end else begin
            r_fetch_pc <= r_fetch_pc + ADDR_W'(w_issue);
            r_out      <= r_out + CW'(w_issue) - CW'(w_keep);
            r_drop     <= r_drop - DW'(imem_rsp_valid && !w_keep);
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
            r_wr       <= r_wr + PW'(w_push);
            r_rd       <= r_rd + PW'(w_pop);
            r_aq_wr    <= r_aq_wr + PW'(w_issue);
            r_aq_rd    <= r_aq_rd + PW'(w_keep);
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) r_aq[r_aq_wr] <= r_fetch_pc;
        if (w_push) begin
            r_data[r_wr] <= imem_rsp_data;
            r_pc[r_wr]   <= r_aq[r_aq_rd];
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] r_stat_fetched, r_stat_flushed, r_stat_stall;
    logic [16:0] w_flush_sum;

    assign w_flush_sum  = {1'b0, r_stat_flushed} + 17'(w_used);
    assign stat_fetched = r_stat_fetched;
    assign stat_flushed = r_stat_flushed;
    assign stat_stall   = r_stat_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_fetched <= '0;
            r_stat_flushed <= '0;
            r_stat_stall   <= '0;
        end else begin
            if (w_pop && r_stat_fetched != 16'hFFFF) r_stat_fetched <= r_stat_fetched + 16'd1;
            if (inst_valid && !inst_ready && r_stat_stall != 16'hFFFF) r_stat_stall <= r_stat_stall + 16'd1;
            if (redirect_valid) r_stat_flushed <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
        end
    end
`endif
endmodule
